// File: rtl/clock_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 Hz prescaler and set-mode FSM.
// Define CLOCK_12H_EN for 12-hour display with PM flag (default: 24-hour).
module clock_time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic [1:0] set_state,
  output logic       tick_1hz,
  output logic       pm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

`ifdef CLOCK_12H_EN
  localparam logic [3:0] HR_HI_RST = 4'd1;
  localparam logic [3:0] HR_LO_RST = 4'd2;
`else
  localparam logic [3:0] HR_HI_RST = 4'd0;
  localparam logic [3:0] HR_LO_RST = 4'd0;
`endif

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [3:0]    sl_q, sl_d, sh_q, sh_d;
  logic [3:0]    ml_q, ml_d, mh_q, mh_d;
  logic [3:0]    hl_q, hl_d, hh_q, hh_d;
  logic          pm_q, pm_d;
  logic          tick_q, tick;
  logic [8:0]    s_inc, m_inc, h_inc;

  // {carry, hi, lo} for a 00..59 BCD field
  function automatic logic [8:0] inc60(
    input logic [3:0] hi,
    input logic [3:0] lo
  );
    if (lo != 4'd9)
      inc60 = {1'b0, hi, lo + 4'd1};
    else if (hi != 4'd5)
      inc60 = {1'b0, hi + 4'd1, 4'd0};
    else
      inc60 = {1'b1, 4'd0, 4'd0};
  endfunction

  // {pm_toggle, hi, lo} for the hour field
  function automatic logic [8:0] inc_hr(
    input logic [3:0] hi,
    input logic [3:0] lo
  );
`ifdef CLOCK_12H_EN
    if (hi == 4'd1 && lo == 4'd1)
      inc_hr = {1'b1, 4'd1, 4'd2};
    else if (hi == 4'd1 && lo == 4'd2)
      inc_hr = {1'b0, 4'd0, 4'd1};
    else if (lo == 4'd9)
      inc_hr = {1'b0, hi + 4'd1, 4'd0};
    else
      inc_hr = {1'b0, hi, lo + 4'd1};
`else
    if (hi == 4'd2 && lo == 4'd3)
      inc_hr = {1'b0, 4'd0, 4'd0};
    else if (lo == 4'd9)
      inc_hr = {1'b0, hi + 4'd1, 4'd0};
    else
      inc_hr = {1'b0, hi, lo + 4'd1};
`endif
  endfunction

  // Next-state: mode FSM, prescaler, time advance and set increments
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    sh_d    = sh_q;
    ml_d    = ml_q;
    mh_d    = mh_q;
    hl_d    = hl_q;
    hh_d    = hh_q;
    pm_d    = pm_q;
    tick    = 1'b0;
    s_inc   = inc60(sh_q, sl_q);
    m_inc   = inc60(mh_q, ml_q);
    h_inc   = inc_hr(hh_q, hl_q);
    unique case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d = SET_HR;
          sl_d    = 4'd0;
          sh_d    = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
          {sh_d, sl_d} = s_inc[7:0];
          if (s_inc[8]) begin
            {mh_d, ml_d} = m_inc[7:0];
            if (m_inc[8]) begin
              {hh_d, hl_d} = h_inc[7:0];
              pm_d = pm_q ^ h_inc[8];
            end
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      SET_HR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
        end else if (btn_inc) begin
          {hh_d, hl_d} = h_inc[7:0];
          pm_d = pm_q ^ h_inc[8];
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (btn_inc) begin
          {mh_d, ml_d} = m_inc[7:0];
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, time digits and delayed tick registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sl_q    <= 4'd0;
      sh_q    <= 4'd0;
      ml_q    <= 4'd0;
      mh_q    <= 4'd0;
      hl_q    <= HR_LO_RST;
      hh_q    <= HR_HI_RST;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sh_q    <= sh_d;
      ml_q    <= ml_d;
      mh_q    <= mh_d;
      hl_q    <= hl_d;
      hh_q    <= hh_d;
      pm_q    <= pm_d;
      tick_q  <= tick;
    end
  end

  assign sec_lo    = sl_q;
  assign sec_hi    = sh_q;
  assign min_lo    = ml_q;
  assign min_hi    = mh_q;
  assign hr_lo     = hl_q;
  assign hr_hi     = hh_q;
  assign set_state = state_q;
  assign tick_1hz  = tick_q;
  assign pm        = pm_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter with CLK_HZ=4.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_clock_time_counter;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic [1:0] set_state;
  logic       tick_1hz;
  logic       pm;

  clock_time_counter #(.CLK_HZ(4)) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .sec_lo(sec_lo),
    .sec_hi(sec_hi),
    .min_lo(min_lo),
    .min_hi(min_hi),
    .hr_lo(hr_lo),
    .hr_hi(hr_hi),
    .set_state(set_state),
    .tick_1hz(tick_1hz),
    .pm(pm)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] t;
    logic [1:0]  st;
    logic        tk;
    logic        p;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;
  bit   flushed = 0;
  logic [23:0] got;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    got = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc || got !== e.t || set_state !== e.st ||
          tick_1hz !== e.tk || pm !== e.p) begin
        miscompares++;
        $display("FAIL %s cyc=%0d: got %h st=%b tk=%b pm=%b, need %h st=%b tk=%b pm=%b @%0d",
                 e.name, cyc, got, set_state, tick_1hz, pm,
                 e.t, e.st, e.tk, e.p, e.cyc);
      end
    end
    if (done && !flushed) begin
      flushed = 1;
      vectors++;
      if (q.size() != 0) begin
        miscompares++;
        $display("FAIL leftover: %0d expectations never checked, need 0", q.size());
      end
    end
  end

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic want(input string n, input int off, input logic [23:0] t,
                      input logic [1:0] st, input logic tk, input logic p);
    exp_t x;
    x.cyc  = cyc + off;
    x.name = n;
    x.t    = t;
    x.st   = st;
    x.tk   = tk;
    x.p    = p;
    q.push_back(x);
  endtask

  initial begin
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(3);
    reset = 1'b0;
`ifdef CLOCK_12H_EN
    want("reset12", 0, 24'h120000, 2'b00, 1'b0, 1'b0);
    step(1);
    press(1, 0);
    want("set_hr12", 0, 24'h120000, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      press(0, 1);
      step(1);
    end
    want("hr_11", 0, 24'h110000, 2'b01, 1'b0, 1'b0);
    press(1, 0);
    for (int i = 1; i <= 59; i++) begin
      press(0, 1);
      step(1);
    end
    want("min_59", 0, 24'h115900, 2'b10, 1'b0, 1'b0);
    press(1, 0);
    want("t_115959", 236, 24'h115959, 2'b00, 1'b1, 1'b0);
    want("to_pm", 240, 24'h120000, 2'b00, 1'b1, 1'b1);
    step(241);
    press(1, 0);
    want("set_hr_pm", 0, 24'h120000, 2'b01, 1'b0, 1'b1);
    press(1, 0);
    for (int i = 1; i <= 59; i++) begin
      press(0, 1);
      step(1);
    end
    press(1, 0);
    want("t_125959", 236, 24'h125959, 2'b00, 1'b1, 1'b1);
    want("to_01", 240, 24'h010000, 2'b00, 1'b1, 1'b1);
    step(241);
    press(1, 0);
    for (int i = 1; i <= 10; i++) begin
      press(0, 1);
      step(1);
    end
    want("set_hr_11pm", 0, 24'h110000, 2'b01, 1'b0, 1'b1);
    press(0, 1);
    want("set_hr_12am", 0, 24'h120000, 2'b01, 1'b0, 1'b0);
`else
    want("reset", 0, 24'h000000, 2'b00, 1'b0, 1'b0);
    want("pre_tick", 3, 24'h000000, 2'b00, 1'b0, 1'b0);
    want("first_tick", 4, 24'h000001, 2'b00, 1'b1, 1'b0);
    want("tick_low", 5, 24'h000001, 2'b00, 1'b0, 1'b0);
    step(5);
    press(1, 0);
    want("enter_set_hr", 0, 24'h000000, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 23; i++) begin
      press(0, 1);
      step(1);
    end
    want("hr_23", 0, 24'h230000, 2'b01, 1'b0, 1'b0);
    press(1, 0);
    want("enter_set_min", 0, 24'h230000, 2'b10, 1'b0, 1'b0);
    for (int i = 1; i <= 59; i++) begin
      press(0, 1);
      step(1);
    end
    want("min_59", 0, 24'h235900, 2'b10, 1'b0, 1'b0);
    press(1, 0);
    want("run_entry", 0, 24'h235900, 2'b00, 1'b0, 1'b0);
    want("sec_58", 233, 24'h235958, 2'b00, 1'b0, 1'b0);
    want("t_235959", 236, 24'h235959, 2'b00, 1'b1, 1'b0);
    want("hold_235959", 239, 24'h235959, 2'b00, 1'b0, 1'b0);
    want("wrap_000000", 240, 24'h000000, 2'b00, 1'b1, 1'b0);
    want("wrap_tick_low", 241, 24'h000000, 2'b00, 1'b0, 1'b0);
    want("sec_37", 389, 24'h000037, 2'b00, 1'b0, 1'b0);
    step(389);
    press(1, 0);
    want("set_clears_sec", 0, 24'h000000, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      press(0, 1);
      step(1);
    end
    want("hr_22", 0, 24'h220000, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      press(0, 1);
      want($sformatf("hr_inc%0d", i), 0,
           {bcd((22 + i) % 24), 16'h0000}, 2'b01, 1'b0, 1'b0);
      step(1);
    end
    press(1, 0);
    want("set_min_again", 0, 24'h230000, 2'b10, 1'b0, 1'b0);
    for (int i = 1; i <= 58; i++) begin
      press(0, 1);
      step(1);
    end
    want("min_58", 0, 24'h235800, 2'b10, 1'b0, 1'b0);
    press(0, 1);
    want("min_59b", 0, 24'h235900, 2'b10, 1'b0, 1'b0);
    step(1);
    press(0, 1);
    want("min_wrap_nocarry", 0, 24'h230000, 2'b10, 1'b0, 1'b0);
    step(1);
    press(0, 1);
    want("min_01", 0, 24'h230100, 2'b10, 1'b0, 1'b0);
    step(1);
    press(1, 1);
    want("mode_inc_min", 0, 24'h230100, 2'b00, 1'b0, 1'b0);
    press(0, 1);
    want("run_inc_ignored", 0, 24'h230100, 2'b00, 1'b0, 1'b0);
    press(1, 0);
    want("reenter_set_hr", 0, 24'h230100, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      press(0, 1);
      step(1);
    end
    want("hr_07", 0, 24'h070100, 2'b01, 1'b0, 1'b0);
    press(1, 1);
    want("mode_inc_hr", 0, 24'h070100, 2'b10, 1'b0, 1'b0);
    reset    = 1'b1;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(1);
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    want("reset_mid_set", 0, 24'h000000, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      want($sformatf("no_tick_%0d", k), k, 24'h000000, 2'b00, 1'b0, 1'b0);
    want("tick_after_reset", 4, 24'h000001, 2'b00, 1'b1, 1'b0);
    step(5);
`endif
    step(2);
    done = 1;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
